// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/extension constants, IR field positions, fetch FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  // Instruction word geometry
  localparam int IR_W = 16;

  // IR field bit ranges
  localparam int IR_OP_MSB   = 15;
  localparam int IR_OP_LSB   = 12;
  localparam int IR_COND_MSB = 11;
  localparam int IR_COND_LSB = 8;
  localparam int IR_DISP_MSB = 7;
  localparam int IR_DISP_LSB = 0;
  localparam int IR_EXT_MSB  = 7;
  localparam int IR_EXT_LSB  = 4;
  localparam int IR_RT_MSB   = 3;
  localparam int IR_RT_LSB   = 0;

  // Control-flow opcodes (IR[15:12]) and jump-kind extensions (IR[7:4])
  localparam logic [3:0] OP_BRANCH = 4'hC;
  localparam logic [3:0] OP_JUMP   = 4'h4;
  localparam logic [3:0] EXT_JCOND = 4'hC;
  localparam logic [3:0] EXT_JAL   = 4'h8;

  // Fetch front-end FSM states
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_FAULT  = 2'd2
  } fetch_state_t;

  // Field view of an instruction word
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] cond;
    logic [3:0] ext;
    logic [3:0] rtarget;
  } ir_fields_t;

  // Split a raw instruction word into its named fields
  function automatic ir_fields_t ir_split(input logic [IR_W-1:0] word);
    return ir_fields_t'(word);
  endfunction

endpackage : cpu_pkg

// File: rtl/instr_decoder.sv
// Control-flow field decoder for one 16-bit instruction word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the IR input continuously.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter logic [3:0] P_OP_BRANCH = OP_BRANCH,
  parameter logic [3:0] P_OP_JUMP   = OP_JUMP,
  parameter logic [3:0] P_EXT_JCOND = EXT_JCOND,
  parameter logic [3:0] P_EXT_JAL   = EXT_JAL
) (
  input  logic [IR_W-1:0] i_ir,
  output logic            o_is_branch,
  output logic            o_is_jump,
  output logic            o_is_jal,
  output logic [3:0]      o_cond,
  output logic [7:0]      o_disp,
  output logic [3:0]      o_rtarget
);

  ir_fields_t w_f;
  logic       w_op_jump;

  assign w_f = ir_split(i_ir);

  // Raw fields pass straight through; displacement stays unsigned here
  assign o_cond    = i_ir[IR_COND_MSB:IR_COND_LSB];
  assign o_disp    = i_ir[IR_DISP_MSB:IR_DISP_LSB];
  assign o_rtarget = i_ir[IR_RT_MSB:IR_RT_LSB];

  // Opcode classification; anything unrecognised leaves all flags low (sequential PC+1)
  always_comb begin
    w_op_jump   = (w_f.opcode == P_OP_JUMP);
    o_is_branch = (w_f.opcode == P_OP_BRANCH);
    o_is_jump   = w_op_jump && (w_f.ext == P_EXT_JCOND);
    o_is_jal    = w_op_jump && (w_f.ext == P_EXT_JAL);
  end

endmodule : instr_decoder

// File: rtl/instruction_fetch.sv
// Fetch/decode front end: reads imem at PC, holds the word in IR, decodes control-flow fields.
// Latency: 2 cycles minimum per instruction (ack in first fetch cycle, exec_ready in first decode cycle).
// Backpressure: exec_ready low holds DECODE with IR frozen; halt stalls FETCH with no request and a frozen timeout.
module instruction_fetch #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [3:0]  OP_BRANCH = cpu_pkg::OP_BRANCH,
  parameter logic [3:0]  OP_JUMP   = cpu_pkg::OP_JUMP,
  parameter logic [3:0]  EXT_JCOND = cpu_pkg::EXT_JCOND,
  parameter logic [3:0]  EXT_JAL   = cpu_pkg::EXT_JAL
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] PC,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        halt,
  input  logic        exec_ready,
  output logic        dec_valid,
  output logic [15:0] instr,
  output logic [3:0]  cond,
  output logic [7:0]  disp,
  output logic [3:0]  rtarget,
  output logic        is_branch,
  output logic        is_jump,
  output logic        is_jal,
  output logic        PC_enb,
  output logic        fault
);

  import cpu_pkg::*;

  // Last wait-count value that may still be rescued by an ack
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  fetch_state_t r_state;
  logic [15:0]  r_ir;
  logic [7:0]   r_wait_cnt;
  logic         r_fault;

  logic w_in_fetch;
  logic w_in_decode;
  logic w_dec_branch;
  logic w_dec_jump;
  logic w_dec_jal;

  // Fetch FSM: owns IR, the imem wait counter and the sticky fault flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_FETCH;
      r_ir       <= 16'h0000;
      r_wait_cnt <= 8'd0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // halt suppresses the request, so neither ack nor timeout can advance
          if (!halt) begin
            if (imem_ack) begin
              // an ack on the final wait cycle still wins over the timeout
              r_ir       <= imem_rdata;
              r_wait_cnt <= 8'd0;
              r_state    <= S_DECODE;
            end else if (r_wait_cnt == WAIT_LAST) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt + 8'd1;
            end
          end
        end
        S_DECODE: begin
          // PC advances on this same edge, so the next fetch sees the new PC
          if (exec_ready) begin
            r_state <= S_FETCH;
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state <= S_FAULT;
          r_fault <= 1'b1;
        end
      endcase
    end
  end

  // Shared decoder, also used further down the pipeline
  instr_decoder #(
    .P_OP_BRANCH (OP_BRANCH),
    .P_OP_JUMP   (OP_JUMP),
    .P_EXT_JCOND (EXT_JCOND),
    .P_EXT_JAL   (EXT_JAL)
  ) u_instr_decoder (
    .i_ir        (r_ir),
    .o_is_branch (w_dec_branch),
    .o_is_jump   (w_dec_jump),
    .o_is_jal    (w_dec_jal),
    .o_cond      (cond),
    .o_disp      (disp),
    .o_rtarget   (rtarget)
  );

  // resetn gates the request so nothing is asserted while reset is held
  assign w_in_fetch  = resetn && (r_state == S_FETCH);
  assign w_in_decode = (r_state == S_DECODE);

  assign imem_req  = w_in_fetch && !halt;
  assign imem_addr = PC;

  // Decoded flags and PC_enb are only meaningful while IR is being offered downstream
  assign dec_valid = w_in_decode;
  assign instr     = r_ir;
  assign is_branch = w_in_decode && w_dec_branch;
  assign is_jump   = w_in_decode && w_dec_jump;
  assign is_jal    = w_in_decode && w_dec_jal;
  assign PC_enb    = w_in_decode && exec_ready;
  assign fault     = r_fault;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios then randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_instruction_fetch;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] PC;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        halt;
  logic        exec_ready;
  logic        dec_valid;
  logic [15:0] instr;
  logic [3:0]  cond;
  logic [7:0]  disp;
  logic [3:0]  rtarget;
  logic        is_branch;
  logic        is_jump;
  logic        is_jal;
  logic        PC_enb;
  logic        fault;

  always #5 clk = ~clk;

  instruction_fetch #(.TIMEOUT(TO)) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .PC         (PC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .halt       (halt),
    .exec_ready (exec_ready),
    .dec_valid  (dec_valid),
    .instr      (instr),
    .cond       (cond),
    .disp       (disp),
    .rtarget    (rtarget),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .is_jal     (is_jal),
    .PC_enb     (PC_enb),
    .fault      (fault)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: is a fetched word waiting for execute, which word, how many
  // requests have gone unanswered, and whether the fetch has given up for good.
  bit          m_have;
  logic [15:0] m_word;
  int          m_waited;
  bit          m_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have   = 1'b0;
    m_word   = 16'h0000;
    m_waited = 0;
    m_fault  = 1'b0;
  endtask

  // Apply one clock edge of the architectural rules to the model
  task automatic model_step();
    if (!resetn || m_fault) return;
    if (m_have) begin
      if (exec_ready) m_have = 1'b0;
    end else if (!halt) begin
      if (imem_ack) begin
        m_word   = imem_rdata;
        m_have   = 1'b1;
        m_waited = 0;
      end else begin
        m_waited = m_waited + 1;
        if (m_waited >= TO) m_fault = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic [15:0] w;
    logic [3:0]  op;
    logic [3:0]  ext;
    w   = m_word;
    op  = w[15:12];
    ext = w[7:4];
    chk({ctx, ".req"},     32'(imem_req),  32'(resetn && !m_fault && !m_have && !halt));
    chk({ctx, ".addr"},    32'(imem_addr), 32'(PC));
    chk({ctx, ".dv"},      32'(dec_valid), 32'(m_have));
    chk({ctx, ".instr"},   32'(instr),     32'(w));
    chk({ctx, ".cond"},    32'(cond),      32'(w[11:8]));
    chk({ctx, ".disp"},    32'(disp),      32'(w[7:0]));
    chk({ctx, ".rt"},      32'(rtarget),   32'(w[3:0]));
    chk({ctx, ".branch"},  32'(is_branch), 32'(m_have && op == 4'hC));
    chk({ctx, ".jump"},    32'(is_jump),   32'(m_have && op == 4'h4 && ext == 4'hC));
    chk({ctx, ".jal"},     32'(is_jal),    32'(m_have && op == 4'h4 && ext == 4'h8));
    chk({ctx, ".pcenb"},   32'(PC_enb),    32'(m_have && exec_ready));
    chk({ctx, ".fault"},   32'(fault),     32'(m_fault));
  endtask

  task automatic settle_check(input string ctx);
    @(negedge clk);
    check_outputs(ctx);
  endtask

  // Clock edge: update model, then advance PC the way program_counter would
  task automatic advance();
    bit enb;
    enb = resetn && m_have && exec_ready;
    model_step();
    @(posedge clk);
    #1;
    if (enb) PC = PC + 16'd1;
  endtask

  task automatic run(input string ctx, input int n);
    for (int i = 0; i < n; i++) begin
      settle_check(ctx);
      advance();
    end
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    check_outputs("rstpulse");
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 4))
      0: w[15:12] = 4'hC;
      1: begin w[15:12] = 4'h4; w[7:4] = 4'hC; end
      2: begin w[15:12] = 4'h4; w[7:4] = 4'h8; end
      3: w[15:12] = 4'h4;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    resetn     = 1'b0;
    PC         = 16'h0000;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    halt       = 1'b0;
    exec_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    settle_check("por");
    chk("por_req", 32'(imem_req), 32'd0);
    advance();
    resetn = 1'b1;

    // 1: branch word, taken straight through
    PC = 16'h0010; imem_ack = 1'b1; imem_rdata = 16'hC1FE; exec_ready = 1'b1;
    settle_check("t1f");
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", 32'(imem_addr), 32'h0010);
    advance();
    imem_ack = 1'b0; imem_rdata = 16'h5555;
    settle_check("t1d");
    chk("t1_dv", 32'(dec_valid), 32'd1);
    chk("t1_branch", 32'(is_branch), 32'd1);
    chk("t1_cond", 32'(cond), 32'h1);
    chk("t1_disp", 32'(disp), 32'hFE);
    chk("t1_pcenb", 32'(PC_enb), 32'd1);
    advance();
    settle_check("t1n");
    chk("t1_dv_off", 32'(dec_valid), 32'd0);
    chk("t1_pcenb_off", 32'(PC_enb), 32'd0);
    chk("t1_addr_next", 32'(imem_addr), 32'h0011);
    advance();

    // 2: Jcond held by execute for three cycles; stray acks must be ignored
    imem_ack = 1'b1; imem_rdata = 16'h40C3; exec_ready = 1'b0;
    run("t2f", 1);
    imem_rdata = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      settle_check("t2h");
      chk("t2_dv", 32'(dec_valid), 32'd1);
      chk("t2_jump", 32'(is_jump), 32'd1);
      chk("t2_rt", 32'(rtarget), 32'h3);
      chk("t2_pcenb_hold", 32'(PC_enb), 32'd0);
      advance();
    end
    exec_ready = 1'b1;
    settle_check("t2r");
    chk("t2_pcenb", 32'(PC_enb), 32'd1);
    chk("t2_instr", 32'(instr), 32'h40C3);
    advance();
    imem_ack = 1'b0;

    // 3: jump-and-link, then an undefined opcode
    imem_ack = 1'b1; imem_rdata = 16'h4085;
    run("t3f", 1);
    imem_ack = 1'b0;
    settle_check("t3d");
    chk("t3_jal", 32'(is_jal), 32'd1);
    chk("t3_jump", 32'(is_jump), 32'd0);
    chk("t3_pcenb", 32'(PC_enb), 32'd1);
    advance();
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    run("t3g", 1);
    imem_ack = 1'b0;
    settle_check("t3u");
    chk("t3_flags", 32'({is_branch, is_jump, is_jal}), 32'd0);
    chk("t3_pcenb_u", 32'(PC_enb), 32'd1);
    advance();

    // 4a: no ack at all -> sixteen requests, then sticky fault
    exec_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      settle_check("t4w");
      chk("t4_req", 32'(imem_req), 32'd1);
      advance();
    end
    exec_ready = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle_check("t4f");
      chk("t4_fault", 32'(fault), 32'd1);
      chk("t4_req_off", 32'(imem_req), 32'd0);
      chk("t4_pcenb", 32'(PC_enb), 32'd0);
      advance();
    end
    imem_ack = 1'b0;
    pulse_reset();

    // 4b: ack arrives on the last allowed wait cycle
    exec_ready = 1'b0;
    run("t4b", TO - 1);
    imem_ack = 1'b1; imem_rdata = 16'hC2AA;
    run("t4b_ack", 1);
    imem_ack = 1'b0;
    settle_check("t4b_d");
    chk("t4b_dv", 32'(dec_valid), 32'd1);
    chk("t4b_fault", 32'(fault), 32'd0);
    exec_ready = 1'b1;
    advance();

    // 5: halt in the middle of a wait; the counter must not advance under halt
    exec_ready = 1'b0;
    run("t5a", 10);
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_ack   = (i % 2 == 0);
      imem_rdata = 16'h7000 + 16'(i);
      settle_check("t5h");
      chk("t5_req", 32'(imem_req), 32'd0);
      advance();
    end
    halt = 1'b0; imem_ack = 1'b0;
    run("t5b", 5);
    imem_ack = 1'b1; imem_rdata = 16'h4081;
    run("t5c", 1);
    imem_ack = 1'b0;
    settle_check("t5d");
    chk("t5_dv", 32'(dec_valid), 32'd1);
    chk("t5_instr", 32'(instr), 32'h4081);
    advance();

    // 6: asynchronous reset while decode is stalled
    #2;
    chk("t6_pre_dv", 32'(dec_valid), 32'd1);
    resetn = 1'b0;
    model_reset();
    #1;
    chk("t6_dv", 32'(dec_valid), 32'd0);
    chk("t6_instr", 32'(instr), 32'd0);
    chk("t6_req", 32'(imem_req), 32'd0);
    chk("t6_flags", 32'({is_branch, is_jump, is_jal, PC_enb}), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    PC = 16'h0040;
    settle_check("t6r");
    chk("t6_req_after", 32'(imem_req), 32'd1);
    chk("t6_addr", 32'(imem_addr), 32'h0040);
    advance();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (!resetn) begin
        resetn = 1'b1;
      end else if ($urandom_range(0, 299) == 0 || (m_fault && $urandom_range(0, 7) == 0)) begin
        resetn = 1'b0;
        model_reset();
      end
      imem_ack   = ($urandom_range(0, 2) == 0);
      imem_rdata = rand_word();
      halt       = ($urandom_range(0, 5) == 0);
      exec_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 49) == 0) PC = 16'($urandom);
      run("rnd", 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_instruction_fetch
